// File: rtl/fpga_pkg.sv
// Shared definitions for the out-channel checker: default word width and
// the checker FSM state encoding.
package fpga_pkg;

    localparam int DefaultMemoryElementWidth = 12;

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        DRAIN,
        DONE
    } checker_state_e;

endpackage

// File: rtl/out_fifo.sv
// Small synchronous FIFO holding out-channel words until they are checked.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module out_fifo #(
    parameter int Width = 12,
    parameter int Depth = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AddrWidth = $clog2(Depth);

    logic [AddrWidth:0]   wr_ptr;
    logic [AddrWidth:0]   rd_ptr;
    logic [Width-1:0]     mem [Depth];

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AddrWidth] != rd_ptr[AddrWidth]) &&
                      (wr_ptr[AddrWidth-1:0] == rd_ptr[AddrWidth-1:0]);
    assign pop_data = mem[rd_ptr[AddrWidth-1:0]];

    // Pointer update; push and pop in the same cycle both advance.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state is written with <= so every register samples pre-edge values.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Word storage write port.
    always_ff @(posedge clock) begin
        // NOTE: storage is not reset; the cleared pointers make old contents unreachable.
        if (push && !full) mem[wr_ptr[AddrWidth-1:0]] <= push_data;
    end

endmodule

// File: rtl/out_channel_checker.sv
// Out-channel checker: loads a table of expected words, accepts the
// producer's out-instruction words through a FIFO, compares them in order
// and reports pass/fail once the producer is done and the FIFO has drained.
module out_channel_checker
    import fpga_pkg::*;
#(
    parameter int MemoryElementWidth = DefaultMemoryElementWidth,
    parameter int NOut               = 16,
    parameter int NExpect            = 16,
    parameter int IndexWidth         = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          exp_valid,
    input  logic [MemoryElementWidth-1:0] exp_data,
    input  logic                          run,
    input  logic                          out_valid,
    input  logic [MemoryElementWidth-1:0] out_data,
    output logic                          out_ready,
    input  logic                          prog_done,
    output logic                          finished,
    output logic                          success,
    output logic [IndexWidth-1:0]         received,
    output logic [IndexWidth-1:0]         first_bad
);

    localparam int CountWidth = $clog2(NExpect + 1);
    localparam int TableAw    = (NExpect > 1) ? $clog2(NExpect) : 1;
    localparam int CmpWidth   = (IndexWidth > CountWidth) ? IndexWidth : CountWidth;

    checker_state_e                state;
    checker_state_e                state_next;
    logic [MemoryElementWidth-1:0] table_mem [NExpect];
    logic [CountWidth-1:0]         exp_count;
    logic                          load_error;
    logic [IndexWidth-1:0]         check_idx;
    logic                          any_bad;
    logic                          push;
    logic                          pop_req;
    logic                          pop;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [MemoryElementWidth-1:0] pop_data;
    logic [CmpWidth-1:0]           idx_ext;
    logic [CmpWidth-1:0]           cnt_ext;
    logic                          word_bad;

    assign push     = out_valid && out_ready;
    assign pop      = pop_req;
    assign finished = (state == DONE);
    assign idx_ext  = CmpWidth'(check_idx);
    assign cnt_ext  = CmpWidth'(exp_count);
    assign word_bad = (idx_ext >= cnt_ext) ||
                      (pop_data != table_mem[check_idx[TableAw-1:0]]);

    out_fifo #(
        .Width (MemoryElementWidth),
        .Depth (NOut)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (out_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= LOAD;
        else       state <= state_next;
    end

    // Next-state, handshake and pop decode.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_next = state;
        out_ready  = 1'b0;
        pop_req    = 1'b0;
        case (state)
            LOAD:  if (run) state_next = RUN;
            RUN: begin
                out_ready = !fifo_full;
                pop_req   = !fifo_empty;
                if (prog_done) state_next = DRAIN;
            end
            DRAIN: begin
                pop_req = !fifo_empty;
                if (fifo_empty) state_next = DONE;
            end
            DONE:    state_next = DONE;
            default: state_next = LOAD;
        endcase
    end

    // Expected-table loading, receive counting, comparison and verdict.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            exp_count  <= '0;
            load_error <= 1'b0;
            check_idx  <= '0;
            any_bad    <= 1'b0;
            first_bad  <= '1;
            received   <= '0;
            success    <= 1'b0;
        end else begin
            if (state == LOAD && exp_valid) begin
                if (exp_count < CountWidth'(NExpect)) exp_count <= exp_count + 1'b1;
                else                                  load_error <= 1'b1;
            end
            if (push && !(&received)) received <= received + 1'b1;
            if (pop) begin
                if (word_bad && !any_bad) begin
                    any_bad   <= 1'b1;
                    first_bad <= check_idx;
                end
                if (!(&check_idx)) check_idx <= check_idx + 1'b1;
            end
            if (state == DRAIN && state_next == DONE)
                success <= !any_bad && !load_error && (idx_ext == cnt_ext);
        end
    end

    // Expected-table write port.
    always_ff @(posedge clock) begin
        if (state == LOAD && exp_valid && exp_count < CountWidth'(NExpect))
            table_mem[exp_count[TableAw-1:0]] <= exp_data;
    end

endmodule
